// File: rtl/hv_alu_pkg.sv
// Shared types for the sequential hypervector ALU processing element.
package hv_alu_pkg;

  typedef enum logic [2:0] {
    OP_XOR    = 3'd0,
    OP_PASS_A = 3'd1,
    OP_PASS_B = 3'd2,
    OP_ROR    = 3'd3,
    OP_ROL    = 3'd4,
    OP_AND    = 3'd5,
    OP_OR     = 3'd6,
    OP_NOT    = 3'd7
  } hv_alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } hv_alu_state_t;

  function automatic logic is_rotate(input hv_alu_op_t op);
    return (op == OP_ROR) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/hv_rot_step.sv
// Combinational rotator covering one iteration of a multi-cycle rotation.
module hv_rot_step #(
  parameter int Width       = 512,
  parameter int MaxShiftAmt = 128,
  parameter int StepWidth   = $clog2(MaxShiftAmt) + 1
) (
  input  logic [Width-1:0]     data,
  input  logic [StepWidth-1:0] step,
  input  logic                 dir_left,
  output logic [Width-1:0]     result
);

  logic [2*Width-1:0] dbl_s;
  logic [2*Width-1:0] shifted_s;

  assign dbl_s = {data, data};

  // Shifting the doubled word turns a rotate into a plain shift; step==Width yields data unchanged.
  always_comb begin
    shifted_s = {(2*Width){1'b0}};
    result    = {Width{1'b0}};
    if (dir_left) begin
      shifted_s = dbl_s << step;
      result    = shifted_s[2*Width-1:Width];
    end else begin
      shifted_s = dbl_s >> step;
      result    = shifted_s[Width-1:0];
    end
  end

endmodule

// File: rtl/hv_alu_pe_seq.sv
// Sequential HV ALU PE: handshaked, registered result, iterative bidirectional rotation.
module hv_alu_pe_seq
  import hv_alu_pkg::*;
#(
  parameter int HVDimension = 512,
  parameter int NumOps      = 8,
  parameter int NumOpsWidth = $clog2(NumOps),
  parameter int MaxShiftAmt = 128,
  parameter int ShiftWidth  = $clog2(HVDimension)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [HVDimension-1:0] A_i,
  input  logic [HVDimension-1:0] B_i,
  input  logic [NumOpsWidth-1:0] op_i,
  input  logic [ShiftWidth-1:0]  shift_amt_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [HVDimension-1:0] C_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   busy_o
);

  localparam int StepWidth = $clog2(MaxShiftAmt) + 1;
  localparam int RemWidth  = ShiftWidth + 1;
  localparam logic [RemWidth-1:0] MaxStepWide = RemWidth'(MaxShiftAmt);

  hv_alu_state_t          state_r;
  hv_alu_op_t             op_s;
  logic [HVDimension-1:0] work_r;
  logic [HVDimension-1:0] c_r;
  logic [HVDimension-1:0] op_res_s;
  logic [HVDimension-1:0] rot_s;
  logic [ShiftWidth-1:0]  rem_r;
  logic [ShiftWidth-1:0]  rem_next_s;
  logic [StepWidth-1:0]   step_s;
  logic                   dir_left_r;
  logic                   valid_r;
  logic                   busy_r;
  logic                   ready_s;
  logic                   accept_s;
  logic                   rot_load_s;

  assign op_s     = hv_alu_op_t'(op_i);
  assign ready_s  = (state_r == IDLE) | ((state_r == DONE) & ready_i);
  assign accept_s = valid_i & ready_s;

  assign ready_o = ready_s;
  assign C_o     = c_r;
  assign valid_o = valid_r;
  assign busy_o  = busy_r;

  // Single-cycle result for the accept cycle; a zero-amount rotate degenerates to pass A.
  always_comb begin
    op_res_s   = {HVDimension{1'b0}};
    rot_load_s = 1'b0;
    case (op_s)
      OP_XOR:    op_res_s = A_i ^ B_i;
      OP_PASS_A: op_res_s = A_i;
      OP_PASS_B: op_res_s = B_i;
      OP_ROR:    op_res_s = A_i;
      OP_ROL:    op_res_s = A_i;
      OP_AND:    op_res_s = A_i & B_i;
      OP_OR:     op_res_s = A_i | B_i;
      OP_NOT:    op_res_s = ~A_i;
      default:   op_res_s = {HVDimension{1'b0}};
    endcase
    if (is_rotate(op_s) && (shift_amt_i != {ShiftWidth{1'b0}})) begin
      rot_load_s = 1'b1;
    end else begin
      rot_load_s = 1'b0;
    end
  end

  // Per-cycle step is min(rem, MaxShiftAmt); rem is widened because MaxShiftAmt may equal HVDimension.
  always_comb begin
    if ({1'b0, rem_r} > MaxStepWide) begin
      step_s = StepWidth'(MaxShiftAmt);
    end else begin
      step_s = StepWidth'(rem_r);
    end
    rem_next_s = rem_r - ShiftWidth'(step_s);
  end

  hv_rot_step #(
    .Width      (HVDimension),
    .MaxShiftAmt(MaxShiftAmt),
    .StepWidth  (StepWidth)
  ) u_rot_step (
    .data    (work_r),
    .step    (step_s),
    .dir_left(dir_left_r),
    .result  (rot_s)
  );

  // Control FSM plus work, remainder, direction and result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= IDLE;
      work_r     <= {HVDimension{1'b0}};
      c_r        <= {HVDimension{1'b0}};
      rem_r      <= {ShiftWidth{1'b0}};
      dir_left_r <= 1'b0;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            busy_r <= 1'b1;
            if (rot_load_s) begin
              work_r     <= A_i;
              rem_r      <= shift_amt_i;
              dir_left_r <= (op_s == OP_ROL);
              state_r    <= SHIFT;
              valid_r    <= 1'b0;
            end else begin
              c_r     <= op_res_s;
              state_r <= DONE;
              valid_r <= 1'b1;
            end
          end else if ((state_r == DONE) && ready_i) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        SHIFT: begin
          work_r <= rot_s;
          rem_r  <= rem_next_s;
          // Final step: publish the rotated word directly, saving a cycle.
          if (rem_next_s == {ShiftWidth{1'b0}}) begin
            c_r     <= rot_s;
            state_r <= DONE;
            valid_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hv_alu_pe_seq.sv
// Scoreboard bench for hv_alu_pe_seq (HVDimension=16, MaxShiftAmt=4, plus a MaxShiftAmt=16 instance).
module tb_hv_alu_pe_seq;

  localparam int D  = 16;
  localparam int M  = 4;
  localparam int SW = 4;

  logic          clk;
  logic          rst_i;
  logic [D-1:0]  A_i, B_i, C_o;
  logic [2:0]    op_i;
  logic [SW-1:0] shift_amt_i;
  logic          valid_i, ready_o, valid_o, ready_i, busy_o;

  logic [D-1:0]  a2, b2, c2;
  logic [2:0]    op2;
  logic [SW-1:0] k2;
  logic          valid2, ready2_o, valid2_o, ready2_i, busy2;

  typedef struct {
    logic [D-1:0] data;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   ready_mode = 0;

  hv_alu_pe_seq #(.HVDimension(D), .NumOps(8), .MaxShiftAmt(M)) dut (
    .clk_i(clk), .rst_i(rst_i), .A_i(A_i), .B_i(B_i), .op_i(op_i),
    .shift_amt_i(shift_amt_i), .valid_i(valid_i), .ready_o(ready_o),
    .C_o(C_o), .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o)
  );

  hv_alu_pe_seq #(.HVDimension(D), .NumOps(8), .MaxShiftAmt(16)) dut2 (
    .clk_i(clk), .rst_i(rst_i), .A_i(a2), .B_i(b2), .op_i(op2),
    .shift_amt_i(k2), .valid_i(valid2), .ready_o(ready2_o),
    .C_o(c2), .valid_o(valid2_o), .ready_i(ready2_i), .busy_o(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Downstream sink: ready_i only changes just after a rising edge.
  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       ready_i = 1'b1;
        1:       ready_i = 1'b0;
        default: ready_i = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
  endfunction

  function automatic logic [D-1:0] ref_result(input logic [2:0] op, input logic [D-1:0] a,
                                              input logic [D-1:0] b, input logic [SW-1:0] k);
    logic [D-1:0] r;
    r = '0;
    case (op)
      3'd0: r = a ^ b;
      3'd1: r = a;
      3'd2: r = b;
      3'd3: for (int i = 0; i < D; i++) r[i] = a[(i + int'(k)) % D];
      3'd4: for (int i = 0; i < D; i++) r[i] = a[(i - int'(k) + D) % D];
      3'd5: r = a & b;
      3'd6: r = a | b;
      default: r = ~a;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [SW-1:0] k);
    if ((op == 3'd3 || op == 3'd4) && k != 0) return 1 + (int'(k) + M - 1) / M;
    return 1;
  endfunction

  // Call right after a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input logic [2:0] op, input logic [D-1:0] a, input logic [D-1:0] b,
                       input logic [SW-1:0] k, input logic [D-1:0] expd, input int lat);
    bit accepted;
    accepted = 1'b0;
    A_i = a; B_i = b; op_i = op; shift_amt_i = k; valid_i = 1'b1;
    for (int t = 0; t < 64 && !accepted; t++) begin
      #1;
      if (ready_o === 1'b1) begin
        sb.push_back('{expd, lat, cyc});
        accepted = 1'b1;
      end
      @(negedge clk);
    end
    valid_i = 1'b0;
    if (!accepted) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && (sb.size() > 0 || valid_o); t++) @(negedge clk);
    check("drain_queue_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: predicts busy/valid/ready from the outstanding queue and pops on each new result.
  initial begin
    exp_t         e;
    bit           had_cur, outstanding, exp_busy, exp_valid;
    logic [D-1:0] cur;
    had_cur = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_i) begin
        had_cur = 1'b0;
      end else begin
        outstanding = 1'b0;
        exp_valid   = had_cur;
        if (sb.size() > 0) begin
          if (sb[0].acc < cyc) begin
            outstanding = 1'b1;
            if (cyc - sb[0].acc >= sb[0].lat) exp_valid = 1'b1;
          end
        end
        exp_busy = had_cur || outstanding;
        check("busy_o", 32'(busy_o), 32'(exp_busy));
        check("valid_o", 32'(valid_o), 32'(exp_valid));
        check("ready_o", 32'(ready_o), 32'(!exp_busy || (exp_valid && ready_i)));
        if (valid_o) begin
          if (!had_cur) begin
            if (sb.size() == 0) begin
              check("unexpected_result", 32'd1, 32'd0);
            end else begin
              e = sb.pop_front();
              check("result", 32'(C_o), 32'(e.data));
              check("latency", cyc - e.acc, e.lat);
            end
            cur = C_o;
          end else begin
            check("hold_C_o", 32'(C_o), 32'(cur));
          end
          had_cur = !ready_i;
        end else begin
          had_cur = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [2:0]    r_op;
    logic [D-1:0]  r_a, r_b, r_exp;
    logic [SW-1:0] r_k;

    rst_i = 1'b1; valid_i = 1'b0; A_i = '0; B_i = '0; op_i = '0; shift_amt_i = '0;
    a2 = '0; b2 = '0; op2 = '0; k2 = '0; valid2 = 1'b0; ready2_i = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_C_o", 32'(C_o), 32'd0);
    check("rst_busy_o", 32'(busy_o), 32'd0);
    check("rst_ready_o", 32'(ready_o), 32'd1);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check("rel_valid_o", 32'(valid_o), 32'd0);
    check("rel_C_o", 32'(C_o), 32'd0);
    check("rel_busy_o", 32'(busy_o), 32'd0);
    @(negedge clk);

    // Logic ops back-to-back, then rotates and their boundaries
    issue(3'd0, 16'hF0F0, 16'hFF00, 4'd0, 16'h0FF0, 1);
    issue(3'd5, 16'hF0F0, 16'hFF00, 4'd0, 16'hF000, 1);
    issue(3'd6, 16'hF0F0, 16'hFF00, 4'd0, 16'hFFF0, 1);
    issue(3'd7, 16'hF0F0, 16'hFF00, 4'd0, 16'h0F0F, 1);
    issue(3'd1, 16'h1234, 16'hABCD, 4'd0, 16'h1234, 1);
    issue(3'd2, 16'h1234, 16'hABCD, 4'd0, 16'hABCD, 1);
    drain();
    issue(3'd3, 16'h0001, 16'h0000, 4'd9, 16'h0080, 4);
    drain();
    issue(3'd4, 16'h0001, 16'h0000, 4'd9, 16'h0200, 4);
    drain();
    issue(3'd3, 16'hA5C3, 16'h0000, 4'd0, 16'hA5C3, 1);
    issue(3'd4, 16'h8001, 16'h0000, 4'd4, 16'h0018, 2);
    drain();
    issue(3'd3, 16'h0001, 16'h0000, 4'd15, 16'h0002, 5);
    drain();

    // Backpressure: five held cycles, then same-cycle drain and accept
    ready_mode = 1;
    issue(3'd0, 16'hAAAA, 16'h5555, 4'd0, 16'hFFFF, 1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ready_o", 32'(ready_o), 32'd0);
      check("bp_valid_o", 32'(valid_o), 32'd1);
      @(negedge clk);
    end
    ready_mode = 0;
    issue(3'd2, 16'h0000, 16'hBEEF, 4'd0, 16'hBEEF, 1);
    issue(3'd6, 16'h0F00, 16'h00F0, 4'd0, 16'h0FF0, 1);
    drain();

    // Randomized traffic with random downstream readiness
    ready_mode = 2;
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      r_op  = 3'($urandom_range(0, 7));
      r_a   = 16'($urandom);
      r_b   = 16'($urandom);
      r_k   = 4'($urandom_range(0, 15));
      r_exp = ref_result(r_op, r_a, r_b, r_k);
      issue(r_op, r_a, r_b, r_k, r_exp, ref_latency(r_op, r_k));
    end
    drain();
    ready_mode = 0;
    @(negedge clk);
    @(negedge clk);

    // Reset during a k=12 rotation
    issue(3'd3, 16'h1234, 16'h0000, 4'd12, ref_result(3'd3, 16'h1234, 16'h0000, 4'd12), 4);
    @(negedge clk);
    rst_i = 1'b1;
    sb.delete();
    #1;
    check("midrst_valid_o", 32'(valid_o), 32'd0);
    check("midrst_busy_o", 32'(busy_o), 32'd0);
    check("midrst_ready_o", 32'(ready_o), 32'd1);
    check("midrst_C_o", 32'(C_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("postrst_valid_o", 32'(valid_o), 32'd0);
    check("postrst_C_o", 32'(C_o), 32'd0);
    @(negedge clk);
    issue(3'd0, 16'h1111, 16'h2222, 4'd0, 16'h3333, 1);
    drain();

    // MaxShiftAmt == HVDimension: k=15 rotate-left finishes in a single shift cycle
    a2 = 16'h0001; op2 = 3'd4; k2 = 4'd15; valid2 = 1'b1;
    #1;
    check("full_ready_o", 32'(ready2_o), 32'd1);
    @(negedge clk);
    valid2 = 1'b0;
    #1;
    check("full_valid_lat1", 32'(valid2_o), 32'd0);
    check("full_busy", 32'(busy2), 32'd1);
    @(negedge clk);
    #1;
    check("full_valid_lat2", 32'(valid2_o), 32'd1);
    check("full_C_o", 32'(c2), 32'h8000);
    @(negedge clk);

    check("final_queue_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
